// File: rtl/pwm_multi_pkg.sv
// Shared register map, CTRL field layout and mode type for the multi-channel PWM block.
package pwm_multi_pkg;

  localparam logic [6:0] ADDR_OUT_EN    = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN    = 7'h01;
  localparam logic [6:0] ADDR_CTRL      = 7'h02;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  localparam int CTRL_MODE_BIT     = 0;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;
  localparam int PRESCALE_W        = CTRL_PRESCALE_MSB - CTRL_PRESCALE_LSB + 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_t;

  // Disabled outputs are forced low; enabled outputs without PWM are held high.
  function automatic logic pwm_out_sel(input logic out_en, input logic pwm_en, input logic pwm);
    logic res;
    if (!out_en) begin
      res = 1'b0;
    end else if (pwm_en) begin
      res = pwm;
    end else begin
      res = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_timebase.sv
// Shared PWM timebase: prescaler, edge/center up-down counter and period-start generation.
module pwm_timebase
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  restart_i,
  input  pwm_mode_t             mode_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  load_o,
  output logic                  period_start_o
);

  localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      CNT_TOP = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [PRESCALE_W-1:0] PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  dir_up_q, dir_up_d;
  logic                  ps_q, ps_d;
  logic                  tick;
  logic                  wrap;

  // Next-state for prescaler and counter; a restart overrides any wrap in the same cycle.
  always_comb begin
    tick     = (psc_q == prescale_i);
    psc_d    = tick ? '0 : (psc_q + PSC_ONE);
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    wrap     = 1'b0;
    if (restart_i) begin
      psc_d    = '0;
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (tick) begin
      case (mode_i)
        MODE_EDGE: begin
          dir_up_d = 1'b1;
          if (cnt_q >= CNT_TOP) begin
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MODE_CENTER: begin
          if (dir_up_q) begin
            if (cnt_q >= CNT_TOP) begin
              cnt_d    = CNT_TOP - CNT_ONE;
              dir_up_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d    = '0;
              dir_up_d = 1'b1;
              wrap     = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          cnt_d    = '0;
          dir_up_d = 1'b1;
          wrap     = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
    ps_d = restart_i | wrap;
  end

  // Timebase state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q    <= '0;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      ps_q     <= 1'b0;
    end else begin
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      ps_q     <= ps_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign load_o         = ps_d;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: register decode, shadowed duty arrays, compare and output registers.
module pwm_multi_channel
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_we,
  input  logic [6:0]          reg_addr,
  input  logic [15:0]         reg_wdata,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  logic [CHANNELS-1:0]             out_en_q, out_en_d;
  logic [CHANNELS-1:0]             pwm_en_q, pwm_en_d;
  pwm_mode_t                       mode_q, mode_d;
  logic [PRESCALE_W-1:0]           prescale_q, prescale_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_pend_q, duty_pend_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
  logic [CHANNELS-1:0]             out_q, out_d;

  logic                we_out_en;
  logic                we_pwm_en;
  logic                we_ctrl;
  logic [CHANNELS-1:0] we_duty;
  logic [WIDTH-1:0]    cnt;
  logic                load;
  logic                unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Address decode; DUTY slots beyond the channel count never match.
  always_comb begin
    we_out_en = reg_we && (reg_addr == ADDR_OUT_EN);
    we_pwm_en = reg_we && (reg_addr == ADDR_PWM_EN);
    we_ctrl   = reg_we && (reg_addr == ADDR_CTRL);
    for (int i = 0; i < CHANNELS; i++) begin
      we_duty[i] = reg_we && (reg_addr == (ADDR_DUTY_BASE + 7'(i)));
    end
  end

  // Control and enable register next-state.
  always_comb begin
    out_en_d   = out_en_q;
    pwm_en_d   = pwm_en_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    if (we_out_en) begin
      out_en_d = reg_wdata[CHANNELS-1:0];
    end else begin
      out_en_d = out_en_q;
    end
    if (we_pwm_en) begin
      pwm_en_d = reg_wdata[CHANNELS-1:0];
    end else begin
      pwm_en_d = pwm_en_q;
    end
    if (we_ctrl) begin
      mode_d     = pwm_mode_t'(reg_wdata[CTRL_MODE_BIT]);
      prescale_d = reg_wdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
    end else begin
      mode_d     = mode_q;
      prescale_d = prescale_q;
    end
  end

  // Pending/active duty and per-channel compare; active duty loads from the pre-write pending value.
  always_comb begin
    duty_pend_d = duty_pend_q;
    duty_act_d  = duty_act_q;
    out_d       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (we_duty[i]) begin
        duty_pend_d[i] = reg_wdata[WIDTH-1:0];
      end else begin
        duty_pend_d[i] = duty_pend_q[i];
      end
      if (load) begin
        duty_act_d[i] = duty_pend_q[i];
      end else begin
        duty_act_d[i] = duty_act_q[i];
      end
      out_d[i] = pwm_out_sel(out_en_q[i], pwm_en_q[i], (cnt < duty_act_q[i]));
    end
  end

  // Register bank, duty arrays and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_q    <= '0;
      pwm_en_q    <= '0;
      mode_q      <= MODE_EDGE;
      prescale_q  <= '0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      out_q       <= '0;
    end else begin
      out_en_q    <= out_en_d;
      pwm_en_q    <= pwm_en_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      out_q       <= out_d;
    end
  end

  pwm_timebase #(
    .WIDTH(WIDTH)
  ) u_timebase (
    .clk_i          (clk),
    .rst_i          (rst),
    .restart_i      (we_ctrl),
    .mode_i         (mode_q),
    .prescale_i     (prescale_q),
    .cnt_o          (cnt),
    .load_o         (load),
    .period_start_o (period_start)
  );

  assign out = out_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with a queue of expected observations.
module tb_pwm_multi_channel;
  import pwm_multi_pkg::*;

  logic        clk;
  logic        rst;
  logic        reg_we;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] out_w;
  logic        period_start;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  pwm_multi_channel #(.CHANNELS(16), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .out          (out_w),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      compare("sb_empty", obs, 32'hDEAD_BEEF);
    end else begin
      e = sb_q.pop_front();
      compare(e.tag, obs, e.val);
    end
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [15:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_we    = 1'b0;
  endtask

  // Returns the number of cycles until period_start is seen (bounded).
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 5000);
    compare("ps_wait", 32'(period_start), 32'd1);
  endtask

  // Measures one period starting at a period_start cycle; optional write at cycle index wr_at.
  task automatic measure(input int ch, input int wr_at, input logic [6:0] a, input logic [15:0] d,
                         output int len, output int high);
    len  = 0;
    high = 0;
    do begin
      if (out_w[ch]) high++;
      reg_we    = (len == wr_at);
      reg_addr  = a;
      reg_wdata = d;
      len++;
      @(negedge clk);
    end while (!period_start && len < 3000);
    reg_we = 1'b0;
  endtask

  initial begin
    int n;
    int len;
    int high;
    rst = 1'b1; reg_we = 1'b0; reg_addr = 7'h00; reg_wdata = 16'h0000;

    // Reset state
    expect_val("rst_out", 32'h0);
    expect_val("rst_ps", 32'h0);
    repeat (3) @(negedge clk);
    check_obs(32'(out_w));
    check_obs(32'(period_start));
    rst = 1'b0;

    expect_val("out_en_all", 32'h0000_FFFF);
    write_reg(ADDR_OUT_EN, 16'hFFFF);
    @(negedge clk);
    check_obs(32'(out_w));

    // Asynchronous reset mid-run
    expect_val("arst_out", 32'h0);
    expect_val("arst_ps", 32'h0);
    #2 rst = 1'b1;
    #1;
    check_obs(32'(out_w));
    check_obs(32'(period_start));
    expect_val("first_period", 32'd255);
    @(negedge clk);
    rst = 1'b0;
    wait_ps(n);
    check_obs(32'(n));

    // Edge mode, channel 3
    expect_val("edge_len", 32'd255);
    expect_val("edge_high", 32'd64);
    write_reg(ADDR_DUTY_BASE + 7'd3, 16'd64);
    write_reg(ADDR_OUT_EN, 16'h0008);
    write_reg(ADDR_PWM_EN, 16'h0008);
    wait_ps(n);
    measure(3, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(len));
    check_obs(32'(high));

    expect_val("dmax_high", 32'd255);
    write_reg(ADDR_DUTY_BASE + 7'd3, 16'd255);
    wait_ps(n);
    measure(3, -1, 7'h00, 16'h0000, len, high);
    measure(3, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(high));

    expect_val("dzero_high", 32'd0);
    write_reg(ADDR_DUTY_BASE + 7'd3, 16'd0);
    wait_ps(n);
    measure(3, -1, 7'h00, 16'h0000, len, high);
    measure(3, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(high));

    // Shadowed duty update on channel 0
    expect_val("sh_cur_high", 32'd50);
    expect_val("sh_cur_len", 32'd255);
    expect_val("sh_next_high", 32'd200);
    expect_val("sh_hold_high", 32'd200);
    expect_val("sh_late_high", 32'd20);
    write_reg(ADDR_DUTY_BASE, 16'd50);
    write_reg(ADDR_OUT_EN, 16'h0001);
    write_reg(ADDR_PWM_EN, 16'h0001);
    wait_ps(n);
    measure(0, 100, ADDR_DUTY_BASE, 16'd200, len, high);
    check_obs(32'(high));
    check_obs(32'(len));
    measure(0, 254, ADDR_DUTY_BASE, 16'd20, len, high);
    check_obs(32'(high));
    measure(0, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(high));
    measure(0, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(high));

    // Center mode, channel 1
    expect_val("c_len", 32'd508);
    expect_val("c_high", 32'd19);
    expect_val("c_mid", 32'd1);
    write_reg(ADDR_DUTY_BASE + 7'd1, 16'd10);
    write_reg(ADDR_OUT_EN, 16'h0002);
    write_reg(ADDR_PWM_EN, 16'h0002);
    write_reg(ADDR_CTRL, 16'h0001);
    wait_ps(n);
    measure(1, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(len));
    check_obs(32'(high));
    check_obs(32'(out_w[1]));

    // Prescaler 3, edge mode, channel 2
    expect_val("p_restart_ps", 32'd1);
    expect_val("p_first_len", 32'd1020);
    expect_val("p_len", 32'd1020);
    expect_val("p_high", 32'd512);
    write_reg(ADDR_DUTY_BASE + 7'd2, 16'd128);
    write_reg(ADDR_OUT_EN, 16'h0004);
    write_reg(ADDR_PWM_EN, 16'h0004);
    write_reg(ADDR_CTRL, 16'h0300);
    check_obs(32'(period_start));
    measure(2, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(len));
    measure(2, -1, 7'h00, 16'h0000, len, high);
    check_obs(32'(len));
    check_obs(32'(high));

    // Enables and register latency
    expect_val("en_off", 32'h0);
    write_reg(ADDR_OUT_EN, 16'h0000);
    @(negedge clk);
    check_obs(32'(out_w));
    write_reg(ADDR_PWM_EN, 16'h0030);
    write_reg(ADDR_DUTY_BASE + 7'd4, 16'd255);
    expect_val("en_1cyc", 32'h0000);
    expect_val("en_2cyc", 32'h00C0);
    write_reg(ADDR_OUT_EN, 16'h00F0);
    check_obs(32'(out_w));
    @(negedge clk);
    check_obs(32'(out_w));

    expect_val("en_pwm", 32'h00D0);
    wait_ps(n);
    @(negedge clk);
    check_obs(32'(out_w));

    expect_val("bad_addr", 32'h00D0);
    write_reg(7'h24, 16'h0000);
    write_reg(7'h40, 16'h0000);
    write_reg(7'h03, 16'h0000);
    wait_ps(n);
    @(negedge clk);
    check_obs(32'(out_w));

    expect_val("pe_1cyc", 32'h00D0);
    expect_val("pe_2cyc", 32'h00F0);
    write_reg(ADDR_PWM_EN, 16'h0000);
    check_obs(32'(out_w));
    @(negedge clk);
    check_obs(32'(out_w));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
